posit_value_mult_pipe_es3: RTL and testbench
============================================

// Module: posit_value_mult_pipe_es3
// PURPOSE
//  Pipelined multiplier core of the es=3 posit datapath. Consumes two decoded `value` operands
//  (posit_defines_es3) and produces an unrounded, normalised `value_product` for the
//  product-to-value narrowing stage directly downstream.
//  Valid/ready streaming, one result per cycle, sideband tag carried through.
// PARAMETERS
//  MULT_STAGES  1  register stages inside the mantissa multiply (legal: 1 or 2)
//  TAG_W        8  width of opaque sideband tag travelling with each operation
// PORTS
//  clk        in   1       sole clock, rising edge
//  reset_n    in   1       asynchronous, active-low reset
//  in_valid   in   1       operand pair valid
//  in_ready   out  1       block can accept operand pair this cycle
//  in1        in   value   operand A (sgn, scale[8:0], fraction[FBITS-1:0], inf, zero)
//  in2        in   value   operand B
//  in_tag     in   TAG_W   sideband tag
//  out_valid  out  1       product valid
//  out_ready  in   1       downstream accepts product
//  out        out  value_product  sgn, scale[9:0], fraction[MBITS-1:0], inf, zero; MBITS=2*FBITS+2
//  out_tag    out  TAG_W   tag of the op in `out`
// BEHAVIOUR
//  - Reset (async assert, sync deassert): every valid flag 0; out/out_tag all-zero; in_ready=1.
//  - Transfer on valid&ready at each side. Stages: S1 capture+special decode, SM multiply
//    (MULT_STAGES regs), SN normalise -> out. Latency in_valid->out_valid = 2+MULT_STAGES cycles.
//  - Per-stage advance: stage k loads when empty or stage k+1 advances (bubbles collapse).
//    in_ready = ~s1_valid | s1_advance. Full throughput 1/cycle with out_ready held high.
//  - out_ready=0 with out_valid=1: out/out_tag held stable; pipeline fills, then in_ready=0.
//    No op lost or duplicated. Order preserved.
//  - Arithmetic: sgn = in1.sgn^in2.sgn. scale = sext10(in1.scale)+sext10(in2.scale) (+1 if
//    P[MSB]); no saturation needed (range -512..511 fits).
//    P = {1,in1.fraction}*{1,in2.fraction} (2*FBITS+2 bits, unsigned).
//    If P[MSB]=1: fraction = {P[MSB-1:0],1'b0}; else fraction = {P[MSB-2:0],2'b00}.
//    Hidden bit dropped, left-aligned, no rounding.
//  - Specials: inf = in1.inf|in2.inf (covers inf*0 = NaR); zero = ~inf & (in1.zero|in2.zero).
//    When inf or zero: sgn, scale, fraction forced to 0.
//  - Unused data regs may hold stale values while their valid=0; out is only meaningful with
//    out_valid.
//  - Reset mid-operation: all in-flight ops discarded, no out_valid pulse after reset release
//    until new input accepted.
// CONFIGURATION
//  POSIT_MULT_OUT_SKID_EN defined: 2-entry skid buffer after SN. in_ready and every
//    stage-advance signal are registered, with no combinational path from out_ready.
//    Latency 3+MULT_STAGES; throughput still 1/cycle.
//  Undefined: no skid buffer; out driven from SN registers; out_ready reaches in_ready
//    combinationally; latency 2+MULT_STAGES.
// TESTING
//  1. 1.5 x 1.5 (scale 0, frac 10..0 each) -> out sgn 0, scale 1, fraction 0010..0 (2.25),
//     out_valid after 2+MULT_STAGES cycles.
//  2. -1.0 x 1.0 (frac 0) -> sgn 1, scale 0, fraction 0; in1.inf=1 x in2.zero=1 -> inf 1,
//     zero 0, sgn/scale/frac 0.
//  3. Scale extremes: 255+255 with frac all-ones -> scale 511;
//     -256 + -256 with frac 0 -> scale -512, fraction 0.
//  4. Stream 16 tagged ops (tags 0..15), random out_ready 50% -> all 16 products emerge in
//     tag order, each matching reference model, out stable while stalled.
//  5. out_ready=0 for 10 cycles with in_valid=1 -> exactly 3+MULT_STAGES ops accepted
//     (no skid: 2+MULT_STAGES), then in_ready=0.
//  6. Assert reset_n low with 3 ops in flight -> out_valid=0, in_ready=1 immediately;
//     no stale products after release.
//     Rerun 1-6 with MULT_STAGES=2 and with/without POSIT_MULT_OUT_SKID_EN.

Source files
------------

// File: rtl/posit_value_mult_pipe_es3.sv
// posit_value_mult_pipe_es3 -- pipelined multiplier core of the es=3 posit datapath.
// Multiplies two decoded posit values and hands an unrounded, normalised product
// (hidden bit dropped, fraction left-aligned) to the narrowing stage downstream.
// Valid/ready streaming, one op per cycle, opaque tag carried alongside each op.
//
// Parameters:
//   MULT_STAGES  register stages inside the mantissa multiply (1 or 2)
//   TAG_W        sideband tag width
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; in1, in2 (value), in_tag
//   out_valid / out_ready product handshake; out (value_product), out_tag
// Build option:
//   POSIT_MULT_OUT_SKID_EN  adds a 2-entry skid buffer after the normalise stage so
//                           that in_ready and all stage advances come from registers
//                           only (one extra cycle of latency). Undefined: out is the
//                           normalise-stage register and out_ready ripples to in_ready.

package posit_defines_es3;
  localparam int unsigned FBITS  = 26;             // fraction bits of a 32-bit es=3 posit
  localparam int unsigned SBITS  = 9;              // operand scale width
  localparam int unsigned PSBITS = SBITS + 1;      // product scale width
  localparam int unsigned MBITS  = 2 * FBITS + 2;  // product fraction width

  typedef struct packed {
    logic              sgn;
    logic [SBITS-1:0]  scale;
    logic [FBITS-1:0]  fraction;
    logic              inf;
    logic              zero;
  } value;

  typedef struct packed {
    logic              sgn;
    logic [PSBITS-1:0] scale;
    logic [MBITS-1:0]  fraction;
    logic              inf;
    logic              zero;
  } value_product;

  // Per-op bookkeeping travelling beside the mantissa multiply
  typedef struct packed {
    logic              sgn;
    logic [PSBITS-1:0] scale;
    logic              inf;
    logic              zero;
  } prod_meta;
endpackage

module posit_value_mult_pipe_es3
  import posit_defines_es3::*;
#(
  parameter int unsigned MULT_STAGES = 1,
  parameter int unsigned TAG_W       = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  value               in1,
  input  value               in2,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output value_product       out,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned MW = FBITS + 1;           // mantissa incl. hidden bit
  localparam int unsigned NS = 2 + MULT_STAGES;     // S1, SM stages, SN
  localparam int unsigned NM = NS - 1;              // stages carrying meta (S1 + SM)

  logic [NS-1:0]    v_q;
  logic [NS-1:0]    v_in;
  logic [NS-1:0]    ld;
  logic             tail_ok;

  prod_meta         meta_s1;
  logic             special_s1;
  prod_meta         meta_q [NM];
  logic [TAG_W-1:0] tag_q  [NM];

  logic [MW-1:0]    mant_a_q;
  logic [MW-1:0]    mant_b_q;
  logic [MBITS-1:0] p_q;

  value_product     sn_d;
  value_product     sn_q;
  logic [TAG_W-1:0] sn_tag_q;

  // Load enables: a stage loads when it is empty or its successor loads
  always_comb begin
    ld = '0;
    ld[NS-1] = ~v_q[NS-1] | tail_ok;
    for (int k = int'(NS) - 2; k >= 0; k--) begin
      ld[k] = ~v_q[k] | ld[k+1];
    end
  end

  assign v_in     = {v_q[NS-2:0], in_valid};
  assign in_ready = ld[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
    end else begin
      v_q <= (v_q & ~ld) | (v_in & ld);
    end
  end

  // Special decode; inf wins over zero so inf*0 yields NaR
  always_comb begin
    meta_s1 = '0;
    if (in1.inf | in2.inf) begin
      meta_s1.inf = 1'b1;
    end else if (in1.zero | in2.zero) begin
      meta_s1.zero = 1'b1;
    end else begin
      meta_s1.sgn   = in1.sgn ^ in2.sgn;
      meta_s1.scale = {in1.scale[SBITS-1], in1.scale} + {in2.scale[SBITS-1], in2.scale};
    end
  end

  assign special_s1 = meta_s1.inf | meta_s1.zero;

  // S1 mantissa capture; specials multiply 0*0 so the fraction comes out zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mant_a_q <= '0;
      mant_b_q <= '0;
    end else if (ld[0] && in_valid) begin
      mant_a_q <= special_s1 ? '0 : {1'b1, in1.fraction};
      mant_b_q <= special_s1 ? '0 : {1'b1, in2.fraction};
    end
  end

  // Meta and tag shift alongside the mantissa path
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(NM); k++) begin
        meta_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      if (ld[0] && in_valid) begin
        meta_q[0] <= meta_s1;
        tag_q[0]  <= in_tag;
      end
      for (int k = 1; k < int'(NM); k++) begin
        if (ld[k] && v_q[k-1]) begin
          meta_q[k] <= meta_q[k-1];
          tag_q[k]  <= tag_q[k-1];
        end
      end
    end
  end

  // Mantissa multiply
  generate
    if (MULT_STAGES == 1) begin : g_mul1
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          p_q <= '0;
        end else if (ld[1] && v_q[0]) begin
          p_q <= MBITS'(mant_a_q) * MBITS'(mant_b_q);
        end
      end
    end else begin : g_mul2
      // Two partial products against the halves of B, summed in the second stage
      localparam int unsigned LO_W = MW / 2;
      localparam int unsigned HI_W = MW - LO_W;
      localparam int unsigned PL_W = MW + LO_W;
      localparam int unsigned PH_W = MW + HI_W;

      logic [PL_W-1:0] pp_lo_q;
      logic [PH_W-1:0] pp_hi_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pp_lo_q <= '0;
          pp_hi_q <= '0;
          p_q     <= '0;
        end else begin
          if (ld[1] && v_q[0]) begin
            pp_lo_q <= PL_W'(mant_a_q) * PL_W'(mant_b_q[LO_W-1:0]);
            pp_hi_q <= PH_W'(mant_a_q) * PH_W'(mant_b_q[MW-1:LO_W]);
          end
          if (ld[2] && v_q[1]) begin
            p_q <= (MBITS'(pp_hi_q) << LO_W) + MBITS'(pp_lo_q);
          end
        end
      end
    end
  endgenerate

  // Normalise: product of two [1,2) mantissas lies in [1,4); drop hidden bit
  always_comb begin
    sn_d      = '0;
    sn_d.sgn  = meta_q[NM-1].sgn;
    sn_d.inf  = meta_q[NM-1].inf;
    sn_d.zero = meta_q[NM-1].zero;
    if (p_q[MBITS-1]) begin
      sn_d.scale    = meta_q[NM-1].scale + PSBITS'(1);
      sn_d.fraction = {p_q[MBITS-2:0], 1'b0};
    end else begin
      sn_d.scale    = meta_q[NM-1].scale;
      sn_d.fraction = {p_q[MBITS-3:0], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sn_q     <= '0;
      sn_tag_q <= '0;
    end else if (ld[NS-1] && v_q[NS-2]) begin
      sn_q     <= sn_d;
      sn_tag_q <= tag_q[NM-1];
    end
  end

`ifdef POSIT_MULT_OUT_SKID_EN
  value_product     sk0_q;
  value_product     sk1_q;
  logic [TAG_W-1:0] sk0_tag_q;
  logic [TAG_W-1:0] sk1_tag_q;
  logic [1:0]       sk_cnt_q;
  logic [1:0]       sk_cnt_d;
  logic             stall_q;
  logic             push;
  logic             pop;

  assign tail_ok  = ~stall_q;
  assign push     = v_q[NS-1] & ~stall_q;
  assign pop      = (sk_cnt_q != 2'd0) & out_ready;
  assign sk_cnt_d = sk_cnt_q + 2'(push) - 2'(pop);

  // Stall is decided a cycle early: stop pushing once the buffer holds an unconsumed
  // entry, so the one push still in flight always finds room.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sk0_q     <= '0;
      sk1_q     <= '0;
      sk0_tag_q <= '0;
      sk1_tag_q <= '0;
      sk_cnt_q  <= '0;
      stall_q   <= 1'b0;
    end else begin
      sk_cnt_q <= sk_cnt_d;
      stall_q  <= (sk_cnt_d == 2'd2) | ((sk_cnt_d == 2'd1) & ~pop);
      if (push && (sk_cnt_q == 2'd0 || (sk_cnt_q == 2'd1 && pop))) begin
        sk0_q     <= sn_q;
        sk0_tag_q <= sn_tag_q;
      end else if (pop && sk_cnt_q == 2'd2) begin
        sk0_q     <= sk1_q;
        sk0_tag_q <= sk1_tag_q;
      end
      if (push && sk_cnt_q == 2'd1 && !pop) begin
        sk1_q     <= sn_q;
        sk1_tag_q <= sn_tag_q;
      end
    end
  end

  assign out_valid = (sk_cnt_q != 2'd0);
  assign out       = sk0_q;
  assign out_tag   = sk0_tag_q;
`else
  assign tail_ok   = out_ready;
  assign out_valid = v_q[NS-1];
  assign out       = sn_q;
  assign out_tag   = sn_tag_q;
`endif

endmodule

// File: tb/tb_posit_value_mult_pipe_es3.sv
// Bench for posit_value_mult_pipe_es3: reset state, directed products, a tagged
// stream under random back-pressure, pipeline fill depth and mid-flight reset.
module tb_posit_value_mult_pipe_es3;
  import posit_defines_es3::*;

  localparam int unsigned MS = 1;
  localparam int unsigned TW = 8;
`ifdef POSIT_MULT_OUT_SKID_EN
  localparam int LAT = 3 + int'(MS);
  localparam int CAP = 3 + int'(MS);
`else
  localparam int LAT = 2 + int'(MS);
  localparam int CAP = 2 + int'(MS);
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  value          in1;
  value          in2;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  value_product  out;
  logic [TW-1:0] out_tag;

  int n_tests = 0;
  int n_fail  = 0;

  value_product  exp_q[$];
  logic [TW-1:0] exp_tag_q[$];
  value          sa [16];
  value          sb [16];

  always #5 clk = ~clk;

  posit_value_mult_pipe_es3 #(.MULT_STAGES(MS), .TAG_W(TW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in1      (in1),
    .in2      (in2),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .out_tag  (out_tag)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic value mk_val(input logic s, input logic [SBITS-1:0] sc,
                                  input logic [FBITS-1:0] f, input logic i, input logic z);
    value r;
    r.sgn = s; r.scale = sc; r.fraction = f; r.inf = i; r.zero = z;
    return r;
  endfunction

  function automatic value_product mk_prod(input logic s, input logic [PSBITS-1:0] sc,
                                           input logic [MBITS-1:0] f, input logic i, input logic z);
    value_product r;
    r.sgn = s; r.scale = sc; r.fraction = f; r.inf = i; r.zero = z;
    return r;
  endfunction

  // Reference product computed with 64-bit integer arithmetic
  function automatic value_product ref_mult(input value a, input value b);
    value_product    r;
    longint unsigned ma, mb, p;
    int              sc;
    r = '0;
    if (a.inf || b.inf) begin
      r.inf = 1'b1;
    end else if (a.zero || b.zero) begin
      r.zero = 1'b1;
    end else begin
      ma = {37'd0, 1'b1, a.fraction};
      mb = {37'd0, 1'b1, b.fraction};
      p  = ma * mb;
      sc = int'($signed(a.scale)) + int'($signed(b.scale));
      if (p[MBITS-1]) begin
        sc = sc + 1;
        p  = p << 1;
      end else begin
        p = p << 2;
      end
      r.sgn      = a.sgn ^ b.sgn;
      r.scale    = sc[PSBITS-1:0];
      r.fraction = p[MBITS-1:0];
    end
    return r;
  endfunction

  // One op through an otherwise empty pipe; checks acceptance, latency, value, tag
  task automatic single_op(input string nm, input value a, input value b,
                           input logic [TW-1:0] t, input value_product e);
    int   cyc;
    logic seen;
    in1 = a; in2 = b; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({nm, "_in_ready"}, 128'(in_ready), 128'(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    cyc  = 1;
    seen = out_valid;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      seen = out_valid;
    end
    check({nm, "_seen"}, 128'(seen), 128'(1'b1));
    check({nm, "_lat"}, 128'(cyc), 128'(LAT));
    check({nm, "_val"}, 128'(out), 128'(e));
    check({nm, "_tag"}, 128'(out_tag), 128'(t));
    @(negedge clk);
  endtask

  initial begin
    int            sent, recv, cyc, acc, stray;
    logic          prev_stall;
    value_product  prev_out, e;
    logic [TW-1:0] prev_tag, et;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in1 = '0; in2 = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_in_ready", 128'(in_ready), 128'(1'b1));
    check("rst_out", 128'(out), 128'(0));
    check("rst_out_tag", 128'(out_tag), 128'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Directed products
    single_op("p1_5x1_5", mk_val(1'b0, 9'h000, 26'h2000000, 1'b0, 1'b0),
              mk_val(1'b0, 9'h000, 26'h2000000, 1'b0, 1'b0), 8'h11,
              mk_prod(1'b0, 10'd1, 54'd1 << 51, 1'b0, 1'b0));
    single_op("neg1x1", mk_val(1'b1, 9'h000, 26'h0, 1'b0, 1'b0),
              mk_val(1'b0, 9'h000, 26'h0, 1'b0, 1'b0), 8'h22,
              mk_prod(1'b1, 10'd0, 54'd0, 1'b0, 1'b0));
    single_op("infxzero", mk_val(1'b0, 9'h005, 26'h155, 1'b1, 1'b0),
              mk_val(1'b1, 9'h1F0, 26'h3, 1'b0, 1'b1), 8'h33,
              mk_prod(1'b0, 10'd0, 54'd0, 1'b1, 1'b0));
    single_op("scale_max", mk_val(1'b0, 9'h0FF, 26'h3FFFFFF, 1'b0, 1'b0),
              mk_val(1'b0, 9'h0FF, 26'h3FFFFFF, 1'b0, 1'b0), 8'h44,
              mk_prod(1'b0, 10'd511, {25'h1FFFFFF, 27'd0, 2'b10}, 1'b0, 1'b0));
    single_op("scale_min", mk_val(1'b0, 9'h100, 26'h0, 1'b0, 1'b0),
              mk_val(1'b0, 9'h100, 26'h0, 1'b0, 1'b0), 8'h55,
              mk_prod(1'b0, 10'h200, 54'd0, 1'b0, 1'b0));
    single_op("p1_25x1_25", mk_val(1'b1, 9'h1FD, 26'h1000000, 1'b0, 1'b0),
              mk_val(1'b0, 9'h007, 26'h1000000, 1'b0, 1'b0), 8'h66,
              mk_prod(1'b1, 10'd4, (54'd1 << 53) | (54'd1 << 50), 1'b0, 1'b0));
    single_op("zeroxval", mk_val(1'b1, 9'h010, 26'h0ABCDEF, 1'b0, 1'b1),
              mk_val(1'b1, 9'h020, 26'h1234567, 1'b0, 1'b0), 8'h77,
              mk_prod(1'b0, 10'd0, 54'd0, 1'b0, 1'b1));

    // Tagged stream with random back-pressure
    for (int i = 0; i < 16; i++) begin
      sa[i] = mk_val(1'($urandom), 9'($urandom), 26'($urandom), 1'b0, 1'b0);
      sb[i] = mk_val(1'($urandom), 9'($urandom), 26'($urandom), 1'b0, 1'b0);
    end
    sa[5].inf  = 1'b1;
    sb[9].zero = 1'b1;
    sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0; prev_tag = '0;
    while (recv < 16 && cyc < 400) begin
      if (prev_stall) begin
        check("hold_valid", 128'(out_valid), 128'(1'b1));
        check("hold_val", 128'(out), 128'(prev_out));
        check("hold_tag", 128'(out_tag), 128'(prev_tag));
      end
      out_ready = 1'($urandom);
      if (sent < 16) begin
        in_valid = 1'b1; in1 = sa[sent]; in2 = sb[sent]; in_tag = TW'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_extra", 128'(exp_q.size()), 128'(1));
        end else begin
          e  = exp_q.pop_front();
          et = exp_tag_q.pop_front();
          check("stream_val", 128'(out), 128'(e));
          check("stream_tag", 128'(out_tag), 128'(et));
          recv++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mult(in1, in2));
        exp_tag_q.push_back(in_tag);
        sent++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_out   = out;
      prev_tag   = out_tag;
      @(negedge clk);
      cyc++;
    end
    check("stream_count", 128'(recv), 128'(16));
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Fill with the output blocked, then drain
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in1 = mk_val(1'b0, 9'(i * 3), 26'(i * 123457), 1'b0, 1'b0);
      in2 = mk_val(1'b1, 9'(i * 5), 26'(i * 654321), 1'b0, 1'b0);
      in_tag = TW'(8'h80 + i);
      #1;
      if (in_ready) begin
        exp_q.push_back(ref_mult(in1, in2));
        exp_tag_q.push_back(in_tag);
        acc++;
      end
      @(negedge clk);
    end
    check("fill_count", 128'(acc), 128'(CAP));
    check("fill_in_ready", 128'(in_ready), 128'(1'b0));
    check("fill_out_valid", 128'(out_valid), 128'(1'b1));
    in_valid = 1'b0; out_ready = 1'b1; recv = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("drain_extra", 128'(exp_q.size()), 128'(1));
        end else begin
          e  = exp_q.pop_front();
          et = exp_tag_q.pop_front();
          check("drain_val", 128'(out), 128'(e));
          check("drain_tag", 128'(out_tag), 128'(et));
          recv++;
        end
      end
      @(negedge clk);
    end
    check("drain_count", 128'(recv), 128'(CAP));

    // Reset with three ops in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in1 = mk_val(1'b0, 9'(i), 26'(i + 1), 1'b0, 1'b0);
      in2 = mk_val(1'b0, 9'(i), 26'(i + 2), 1'b0, 1'b0);
      in_tag = TW'(8'hC0 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_out_valid", 128'(out_valid), 128'(1'b1));
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(1'b1));
    repeat (2) @(negedge clk);
    reset_n = 1'b1; out_ready = 1'b1; stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("post_rst_stray", 128'(stray), 128'(0));
    single_op("post_rst", mk_val(1'b0, 9'h000, 26'h2000000, 1'b0, 1'b0),
              mk_val(1'b0, 9'h000, 26'h2000000, 1'b0, 1'b0), 8'h99,
              mk_prod(1'b0, 10'd1, 54'd1 << 51, 1'b0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
